// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised overflow counter.
package counter_pkg;

    // Behaviour at the count limits: roll over or hold.
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Default counter width, matching the original 8-bit counter.
    localparam int unsigned CNT_DEFAULT_WIDTH = 32'd8;

endpackage : counter_pkg

// File: rtl/cnt_flag_reg.sv
// Sticky status bit: set latches it, clr drops it, set wins a simultaneous clr.
module cnt_flag_reg (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_r;

    // Sticky bit register; asynchronous active-low reset, set has priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_r <= 1'b0;
        end else if (set) begin
            flag_r <= 1'b1;
        end else if (clr) begin
            flag_r <= 1'b0;
        end else begin
            flag_r <= flag_r;
        end
    end

    assign flag = flag_r;

endmodule : cnt_flag_reg

// File: rtl/counter_ovf_param.sv
// Parametrised up/down counter with registered overflow/underflow pulses,
// wrap or saturate behaviour at the limits, synchronous load with clamping
// and a combinational terminal-count output.
// Optional feature: define OVF_STICKY_EN to build the sticky ovf/unf flag
// registers (cleared by clr_flags); otherwise the sticky outputs read 0.
module counter_ovf_param
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = CNT_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter cnt_mode_e        MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             ovf_r;
    logic             unf_r;
    logic             ovf_next_s;
    logic             unf_next_s;

    // Next count and limit-crossing pulses; priority is load, then enable, then hold.
    always_comb begin
        count_next_s = count_r;
        ovf_next_s   = 1'b0;
        unf_next_s   = 1'b0;
        if (load) begin
            // Out-of-range load values clamp silently to the terminal value.
            if (load_val > MAX_VAL) begin
                count_next_s = MAX_VAL;
            end else begin
                count_next_s = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (count_r == MAX_VAL) begin
                    ovf_next_s = 1'b1;
                    case (MODE)
                        CNT_WRAP: count_next_s = CNT_ZERO;
                        CNT_SAT:  count_next_s = count_r;
                        default:  count_next_s = count_r;
                    endcase
                end else begin
                    count_next_s = count_r + CNT_ONE;
                end
            end else begin
                if (count_r == CNT_ZERO) begin
                    unf_next_s = 1'b1;
                    case (MODE)
                        CNT_WRAP: count_next_s = MAX_VAL;
                        CNT_SAT:  count_next_s = count_r;
                        default:  count_next_s = count_r;
                    endcase
                end else begin
                    count_next_s = count_r - CNT_ONE;
                end
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and one-cycle pulse registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            ovf_r   <= ovf_next_s;
            unf_r   <= unf_next_s;
        end
    end

    assign count = count_r;
    assign ovf   = ovf_r;
    assign unf   = unf_r;
    assign tc    = up_dn ? (count_r == MAX_VAL) : (count_r == CNT_ZERO);

`ifdef OVF_STICKY_EN
    // Sticky flags set on the same edge that sets the corresponding pulse.
    cnt_flag_reg u_ovf_flag (
        .clk   (clk),
        .reset (reset),
        .set   (ovf_next_s),
        .clr   (clr_flags),
        .flag  (ovf_sticky)
    );

    cnt_flag_reg u_unf_flag (
        .clk   (clk),
        .reset (reset),
        .set   (unf_next_s),
        .clr   (clr_flags),
        .flag  (unf_sticky)
    );
`else
    // Without sticky flags the clear input has no function.
    logic unused_clr_flags_s;
    assign unused_clr_flags_s = clr_flags;
    assign ovf_sticky         = 1'b0;
    assign unf_sticky         = 1'b0;
`endif

endmodule : counter_ovf_param

// File: tb/tb_counter_ovf_param.sv
// Directed bench for counter_ovf_param: a table of vectors on the default
// 8-bit wrapping counter, plus hand sequences on a MAX_VAL=9 saturating
// instance and for asynchronous reset.
module tb_counter_ovf_param;
    import counter_pkg::*;

`ifdef OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    typedef struct {
        logic       load;
        logic [7:0] load_val;
        logic       en;
        logic       up_dn;
        logic       clr;
        logic [7:0] exp_count;
        logic       exp_tc;
        logic       exp_ovf;
        logic       exp_unf;
        logic       exp_os;
        logic       exp_us;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    // Instance A: WIDTH=8, MAX_VAL=255, wrap
    logic       a_en = 1'b0, a_up_dn = 1'b0, a_load = 1'b0, a_clr = 1'b0;
    logic [7:0] a_load_val = 8'd0;
    logic [7:0] a_count;
    logic       a_tc, a_ovf, a_unf, a_os, a_us;

    // Instance B: WIDTH=8, MAX_VAL=9, saturate
    logic       b_en = 1'b0, b_up_dn = 1'b0, b_load = 1'b0, b_clr = 1'b0;
    logic [7:0] b_load_val = 8'd0;
    logic [7:0] b_count;
    logic       b_tc, b_ovf, b_unf, b_os, b_us;

    int checks = 0;
    int errors = 0;

    vec_t tbl [18];

    counter_ovf_param dut_a (
        .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up_dn), .load(a_load),
        .load_val(a_load_val), .clr_flags(a_clr), .count(a_count), .tc(a_tc),
        .ovf(a_ovf), .unf(a_unf), .ovf_sticky(a_os), .unf_sticky(a_us)
    );

    counter_ovf_param #(.WIDTH(8), .MAX_VAL(8'd9), .MODE(CNT_SAT)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .up_dn(b_up_dn), .load(b_load),
        .load_val(b_load_val), .clr_flags(b_clr), .count(b_count), .tc(b_tc),
        .ovf(b_ovf), .unf(b_unf), .ovf_sticky(b_os), .unf_sticky(b_us)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_a(input string nm, input logic [7:0] c, input logic t,
                           input logic o, input logic u, input logic os, input logic us);
        check({nm, " count"}, {24'd0, a_count}, {24'd0, c});
        check({nm, " tc"}, {31'd0, a_tc}, {31'd0, t});
        check({nm, " ovf"}, {31'd0, a_ovf}, {31'd0, o});
        check({nm, " unf"}, {31'd0, a_unf}, {31'd0, u});
        check({nm, " ovf_sticky"}, {31'd0, a_os}, {31'd0, os & STICKY});
        check({nm, " unf_sticky"}, {31'd0, a_us}, {31'd0, us & STICKY});
    endtask

    task automatic step_b(input string nm, input logic ld, input logic [7:0] lv, input logic e,
                          input logic ud, input logic [7:0] c, input logic t, input logic o, input logic u);
        b_load = ld; b_load_val = lv; b_en = e; b_up_dn = ud;
        @(posedge clk); #1;
        check({nm, " count"}, {24'd0, b_count}, {24'd0, c});
        check({nm, " tc"}, {31'd0, b_tc}, {31'd0, t});
        check({nm, " ovf"}, {31'd0, b_ovf}, {31'd0, o});
        check({nm, " unf"}, {31'd0, b_unf}, {31'd0, u});
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          load lv      en    up    clr  | count  tc    ovf   unf   os    us
        tbl[0]  = '{1'b1, 8'd254, 1'b0, 1'b1, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h80,  1'b0, 1'b0, 1'b0, 8'h80,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 13; i < 18; i++) begin
            tbl[i] = '{1'b0, 8'd0, 1'b0, logic'(i[0]), 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end

        // Reset state before any clock edge; up_dn=0 so tc reads 1.
        #3;
        check_a("reset_a", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_b count", {24'd0, b_count}, 32'd0);
        check("reset_b tc", {31'd0, b_tc}, 32'd1);
        reset = 1'b1;

        // Table on the wrapping instance.
        for (int i = 0; i < 18; i++) begin
            a_load = tbl[i].load; a_load_val = tbl[i].load_val; a_en = tbl[i].en;
            a_up_dn = tbl[i].up_dn; a_clr = tbl[i].clr;
            @(posedge clk); #1;
            check_a($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_tc, tbl[i].exp_ovf,
                    tbl[i].exp_unf, tbl[i].exp_os, tbl[i].exp_us);
        end
        a_load = 1'b0; a_en = 1'b0; a_clr = 1'b0;

        // Saturating instance, MAX_VAL=9.
        step_b("b_load1",    1'b1, 8'd1,   1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        step_b("b_dn_to0",   1'b0, 8'd0,   1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step_b("b_sat_dn1",  1'b0, 8'd0,   1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step_b("b_sat_dn2",  1'b0, 8'd0,   1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step_b("b_hold0",    1'b0, 8'd0,   1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step_b("b_load9",    1'b1, 8'd9,   1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        step_b("b_sat_up1",  1'b0, 8'd0,   1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 1'b0);
        step_b("b_sat_up2",  1'b0, 8'd0,   1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 1'b0);
        step_b("b_ld_clamp", 1'b1, 8'd200, 1'b1, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        step_b("b_ld_clmp2", 1'b1, 8'd200, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0);
        step_b("b_dn_9to8",  1'b0, 8'd0,   1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 1'b0);
        check("b ovf_sticky", {31'd0, b_os}, {31'd0, STICKY});
        check("b unf_sticky", {31'd0, b_us}, {31'd0, STICKY});
        b_en = 1'b0; b_load = 1'b0;

        // Asynchronous reset mid-count at 0x37, no clock edge required.
        a_load = 1'b1; a_load_val = 8'h37; a_up_dn = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
        check("rst_pre count", {24'd0, a_count}, 32'h37);
        #2 reset = 1'b0;
        #1;
        check_a("rst_async", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_async b count", {24'd0, b_count}, 32'd0);
        a_up_dn = 1'b0;
        #1;
        check("rst_tc_dn", {31'd0, a_tc}, 32'd1);
        reset = 1'b1;
        // First edge after release counts from zero.
        a_en = 1'b1; a_up_dn = 1'b1;
        @(posedge clk); #1;
        check_a("rst_release", 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during an ovf pulse clears the pulse and sticky flag at once.
        a_en = 1'b0; a_load = 1'b1; a_load_val = 8'd255;
        @(posedge clk); #1;
        a_load = 1'b0; a_en = 1'b1;
        @(posedge clk); #1;
        check_a("pre_rst_ovf", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        a_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_a("rst_in_ovf", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_ovf_param
